lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator that drives the data memory's mem_read/mem_write/addr/write_data interface from core pipeline requests.
- Handles byte/half/word sizing, sign extension and sub-word store read-modify-write.
- Checks alignment and range, and applies the PMP verdict before any memory access.
- Generates a clean single-cycle mem_write pulse, because the data memory commits on the rising edge of mem_write.

Parameters:
- MEM_WORDS, 512, number of 32-bit words in the data memory.
- WORD_AW, 9, word-address width; must satisfy 2**WORD_AW == MEM_WORDS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- req_unsigned  in  1  zero-extend loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- pmp_allow  in  1  PMP verdict for req_addr/req_we, sampled at accept
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  load result; 0 for stores and faults
- rsp_fault  out  1  request aborted
- rsp_cause  out  2  00 none, 01 misaligned, 10 out of range, 11 PMP deny
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write pulse
- mem_addr  out  WORD_AW  word address (req_addr[WORD_AW+1:2])
- mem_wdata  out  32  full-word write data
- mem_rdata  in  32  combinational read data from memory

Behaviour:
Reset and handshake:
- Reset (asynchronous, any state): state=IDLE; every output 0 except req_ready=1.
- Accept when req_valid && req_ready. All request fields, including pmp_allow, are registered at accept.
- rsp_valid lasts one cycle, with no backpressure. req_ready returns to 1 the cycle after RESP.

Fault check at accept:
- Priority: misaligned > range > PMP.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- Out of range: req_addr >= MEM_WORDS*4.
- On a fault: go to RESP with rsp_fault=1, cause set, rdata=0. mem_read and mem_write are never asserted.

States:
- IDLE: wait for accept; go to FAULT-RESP, READ, RMW_READ or W_SETUP.
- READ: mem_read=1, mem_addr valid. Capture mem_rdata at the clock edge, then go to RESP.
- RMW_READ: same as READ. Merge the store lane into the captured word to form mem_wdata, then go to W_SETUP.
- W_SETUP: mem_addr and mem_wdata stable, mem_write=0.
- W_PULSE: mem_write=1 for exactly one cycle.
- W_HOLD: mem_write=0, mem_addr and mem_wdata still held; then go to RESP.
- RESP: rsp_valid=1, then IDLE.

Latency (accept at T0):
- Fault: RESP at T1.
- Load: RESP at T2.
- Word store: RESP at T4.
- Byte/half store: RESP at T5.

Data paths:
- mem_read and mem_write are never high together.
- mem_addr/mem_wdata are registered and change only on entry to READ, RMW_READ or W_SETUP.
- Load lane select: byte lane = addr[1:0]; half lane = addr[1]. Sign-extend unless req_unsigned.
- Store merge replaces only the addressed lane; the other bytes come from the RMW read.

Reset mid-operation:
- Abort; no response.
- If reset arrives in W_PULSE, the memory write has already occurred. If it arrives earlier, no write occurs.
- mem_write deasserts asynchronously.

Decomposition:
- Package lsu_pkg holds: size encodings (SZ_B, SZ_H, SZ_W), cause codes (C_NONE, C_MISAL, C_RANGE, C_PMP), and the state enum.
- One sub-module, lsu_lane_align (combinational): load extract/extend and store lane merge. This lets it be unit-tested separately.

Test Plan:
- Load unsigned byte 0x401, memory word 256 = 0x12345678 -> rsp at T2, rdata=0x00000056, fault=0, exactly one mem_read cycle.
- Load signed byte 0x407, word 257 = 0x9ABCDEF0 -> rdata=0xFFFFFF9A; the same request with unsigned=1 -> 0x0000009A.
- Store half 0xBEEF at 0x402 -> word 256 becomes 0xBEEF5678, rsp at T5, one RMW mem_read, exactly one mem_write pulse, mem_addr=0x100 steady from W_SETUP through W_HOLD.
- Word load at 0x002 -> rsp at T1, fault=1, cause=01, mem_read never asserted. Word load at 0x800 -> cause=10.
- Word store 0xCAFEBABE at 0x000 with pmp_allow=0 -> cause=11, word 0 stays 0x00000001, mem_write never asserted.
- Back-to-back requests with req_valid held high -> second accept one cycle after RESP. Reset asserted during W_SETUP -> no write, all outputs 0, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory master: access sizes, fault causes
// and controller states.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_MISAL = 2'b01;
  localparam logic [1:0] C_RANGE = 2'b10;
  localparam logic [1:0] C_PMP   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_RMW_READ,
    ST_W_SETUP,
    ST_W_PULSE,
    ST_W_HOLD,
    ST_RESP
  } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a load value from a memory word,
// and merges a right-aligned store value into the addressed lane of a word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  byte_off,
  input  logic        is_unsigned,
  input  logic [31:0] word_in,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = word_in[{byte_off, 3'b000} +: 8];
    lane_h    = byte_off[1] ? word_in[31:16] : word_in[15:0];
    load_data = word_in;
    merged    = store_data;
    case (size)
      SZ_B: begin
        load_data = is_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
        merged    = word_in;
        merged[{byte_off, 3'b000} +: 8] = store_data[7:0];
      end
      SZ_H: begin
        load_data = is_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
        merged    = word_in;
        if (byte_off[1]) merged[31:16] = store_data[15:0];
        else             merged[15:0]  = store_data[15:0];
      end
      default: begin
        load_data = word_in;
        merged    = store_data;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: checks alignment/range/PMP, then sequences reads,
// read-modify-write stores and a single-cycle mem_write pulse.
module lsu_mem_master #(
  parameter int MEM_WORDS = 512,
  parameter int WORD_AW   = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic               pmp_allow,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_fault,
  output logic [1:0]         rsp_cause,
  output logic               mem_read,
  output logic               mem_write,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  import lsu_pkg::*;

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  state_t state_q, state_d;

  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [1:0]         off_q, off_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         cause_q, cause_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [WORD_AW-1:0] addr_q, addr_d;
  logic [31:0]        mwdata_q, mwdata_d;

  logic        misal;
  logic [1:0]  cause_in;
  logic [31:0] ld_data;
  logic [31:0] st_merged;

  lsu_lane_align u_align (
    .size        (size_q),
    .byte_off    (off_q),
    .is_unsigned (uns_q),
    .word_in     (mem_rdata),
    .store_data  (wdata_q),
    .load_data   (ld_data),
    .merged      (st_merged)
  );

  always_comb begin
    misal    = ((req_size == SZ_H) && req_addr[0]) ||
               (req_size[1] && (req_addr[1:0] != 2'b00));
    cause_in = misal                    ? C_MISAL :
               (req_addr >= ADDR_LIMIT) ? C_RANGE :
               !pmp_allow               ? C_PMP   : C_NONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      off_q    <= '0;
      wdata_q  <= '0;
      cause_q  <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      cause_q  <= cause_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      mwdata_q <= mwdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (cause_in != C_NONE) state_d = ST_RESP;
          else if (!req_we)       state_d = ST_READ;
          else if (req_size[1])   state_d = ST_W_SETUP;
          else                    state_d = ST_RMW_READ;
        end
      end
      ST_READ:     state_d = ST_RESP;
      ST_RMW_READ: state_d = ST_W_SETUP;
      ST_W_SETUP:  state_d = ST_W_PULSE;
      ST_W_PULSE:  state_d = ST_W_HOLD;
      ST_W_HOLD:   state_d = ST_RESP;
      ST_RESP:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // mem_addr/mem_wdata load only on entry to READ, RMW_READ or W_SETUP.
  always_comb begin
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    cause_d  = cause_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    mwdata_d = mwdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          cause_d = cause_in;
          rdata_d = '0;
          if (cause_in == C_NONE) begin
            addr_d = req_addr[WORD_AW+1:2];
            if (req_we && req_size[1]) mwdata_d = req_wdata;
          end
        end
      end
      ST_READ:     rdata_d  = ld_data;
      ST_RMW_READ: mwdata_d = st_merged;
      default: ;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    rsp_fault = rsp_valid && (cause_q != C_NONE);
    rsp_cause = rsp_valid ? cause_q : C_NONE;
    rsp_rdata = rsp_valid ? rdata_q : '0;
    mem_read  = (state_q == ST_READ) || (state_q == ST_RMW_READ);
    mem_write = (state_q == ST_W_PULSE);
    mem_addr  = addr_q;
    mem_wdata = mwdata_q;
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: a byte-level reference model predicts each
// response; a negedge monitor checks responses, latency and memory traffic.
module tb_lsu_mem_master;

  localparam int MEM_WORDS = 512;
  localparam int WORD_AW   = 9;

  logic               clk;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [1:0]         req_size;
  logic               req_unsigned;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic               pmp_allow;
  logic               rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               rsp_fault;
  logic [1:0]         rsp_cause;
  logic               mem_read;
  logic               mem_write;
  logic [WORD_AW-1:0] mem_addr;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;

  lsu_mem_master #(.MEM_WORDS(MEM_WORDS), .WORD_AW(WORD_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .pmp_allow(pmp_allow),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .rsp_cause(rsp_cause), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_arr [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  int          wr_total = 0;

  assign mem_rdata = mem_arr[mem_addr];
  always @(posedge mem_write) begin
    mem_arr[mem_addr] = mem_wdata;
    wr_total++;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  cause;
    int          lat;
    int          reads;
    int          writes;
    int          word;
    logic [31:0] wval;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte arithmetic on the shadow memory.
  function automatic exp_t model(input bit we, input logic [1:0] sz, input bit uns,
                                 input logic [31:0] a, input logic [31:0] wd, input bit pmp);
    exp_t        e;
    int          nb;
    int          off;
    longint      mask;
    logic [31:0] v;
    nb     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off    = int'(a % 4);
    mask   = (64'd1 << (8 * nb)) - 1;
    e.word = int'((a / 4) % MEM_WORDS);
    e.rdata = 32'h0; e.fault = 1'b0; e.cause = 2'd0;
    e.reads = 0; e.writes = 0; e.lat = 1;
    if (a % nb != 0)          e.cause = 2'd1;
    else if (a >= MEM_WORDS * 4) e.cause = 2'd2;
    else if (!pmp)            e.cause = 2'd3;
    if (e.cause != 2'd0) begin
      e.fault = 1'b1;
    end else if (!we) begin
      v = 32'((longint'(ref_mem[e.word]) >> (8 * off)) & mask);
      if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~32'(mask);
      e.rdata = v;
      e.lat = 2; e.reads = 1;
    end else begin
      ref_mem[e.word] = 32'((longint'(ref_mem[e.word]) & ~(mask << (8 * off))) |
                            ((longint'(wd) & mask) << (8 * off)));
      e.lat = (nb == 4) ? 4 : 5;
      e.reads = (nb == 4) ? 0 : 1;
      e.writes = 1;
    end
    e.wval = ref_mem[e.word];
    return e;
  endfunction

  int cyc = 0;
  int acc_cyc = 0;
  int rd_cnt = 0;
  int wr_snap = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        rd_cnt = 0;
      end else begin
        if (mem_read && mem_write) chk("rd_wr_overlap", 32'd1, 32'd0);
        if (mem_read) rd_cnt++;
        if (mem_write && q.size() > 0) chk("wr_addr", 32'(mem_addr), 32'(q[0].word));
        if (rsp_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("rdata",   rsp_rdata, e.rdata);
            chk("fault",   32'(rsp_fault), 32'(e.fault));
            chk("cause",   32'(rsp_cause), 32'(e.cause));
            chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
            chk("reads",   32'(rd_cnt), 32'(e.reads));
            chk("writes",  32'(wr_total - wr_snap), 32'(e.writes));
            chk("memword", mem_arr[e.word], e.wval);
          end
        end
        if (req_valid && req_ready) begin
          acc_cyc = cyc;
          rd_cnt  = 0;
          wr_snap = wr_total;
        end
      end
    end
  end

  task automatic issue(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                       input logic [31:0] wd, input bit pmp, input bit hold, input int exp_wait);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; pmp_allow = pmp;
    forever begin
      @(negedge clk);
      n++;
      if (req_ready) break;
      if (n > 50) begin
        chk("accept_timeout", 32'd1, 32'd0);
        req_valid = 1'b0;
        return;
      end
    end
    if (exp_wait > 0) chk("b2b_accept_wait", 32'(n), 32'(exp_wait));
    q.push_back(model(we, sz, uns, a, wd, pmp));
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; pmp_allow = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) mem_arr[i] = $urandom;
    mem_arr[0] = 32'h00000001;
    mem_arr[256] = 32'h12345678;
    mem_arr[257] = 32'h9ABCDEF0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = mem_arr[i];

    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_read",  32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr",  32'(mem_addr), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, 2'd0, 1'b1, 32'h401, 32'h0, 1'b1, 1'b0, 0);
    issue(1'b0, 2'd0, 1'b0, 32'h407, 32'h0, 1'b1, 1'b0, 0);
    issue(1'b0, 2'd0, 1'b1, 32'h407, 32'h0, 1'b1, 1'b0, 0);
    issue(1'b1, 2'd1, 1'b0, 32'h402, 32'h0000BEEF, 1'b1, 1'b0, 0);
    drain();
    chk("half_store_word256", mem_arr[256], 32'hBEEF5678);
    issue(1'b0, 2'd2, 1'b0, 32'h002, 32'h0, 1'b1, 1'b0, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h800, 32'h0, 1'b1, 1'b0, 0);
    issue(1'b1, 2'd2, 1'b0, 32'h000, 32'hCAFEBABE, 1'b0, 1'b0, 0);
    drain();
    chk("pmp_word0_kept", mem_arr[0], 32'h00000001);

    // Back-to-back: a load takes READ, RESP, then IDLE accepts on the third negedge.
    issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b1, 1'b1, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 1'b1, 1'b1, 3);
    issue(1'b1, 2'd3, 1'b0, 32'h408, 32'h13579BDF, 1'b1, 1'b0, 3);
    drain();

    // Reset while the word store sits in W_SETUP: no write, no response.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h10;
    req_wdata = 32'hDEADBEEF; pmp_allow = 1'b1;
    @(negedge clk);
    chk("rst_test_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_write", 32'(mem_write), 32'd0);
    chk("midrst_mem_read",  32'(mem_read), 32'd0);
    chk("midrst_mem_addr",  32'(mem_addr), 32'd0);
    chk("midrst_mem_wdata", mem_wdata, 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_word4_kept", mem_arr[4], ref_mem[4]);
    chk("midrst_ready_after", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    for (int t = 0; t < 200; t++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, MEM_WORDS * 4 - 1));
      if ($urandom_range(0, 3) != 0) a = (sz == 2'd0) ? a : (sz == 2'd1) ? (a & ~32'd1) : (a & ~32'd3);
      if ($urandom_range(0, 9) == 0) a = a + 32'(MEM_WORDS * 4) * 32'($urandom_range(1, 4));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
            ($urandom_range(0, 7) != 0), 1'b0, 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
